// File: rtl/sent_rx.sv
// sent_rx: single-channel SENT (SAE J2716) receiver/decoder.
// It measures the interval between falling edges in ticks, classifies each
// interval as sync or nibble, and presents every completed frame as a
// one-cycle strobe.
// Optional CRC checking is enabled by defining SENT_RX_CRC_CHECK_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HUNT   | idle or timed out; the first falling edge starts timing
// ST_SYNC   | waiting for a 56-tick sync interval; pauses are ignored here
// ST_STATUS | expecting the status/comm nibble
// ST_DATA   | collecting data nibbles, first nibble ends up in the MSBs
// ST_CRC    | expecting the CRC nibble that completes the frame
module sent_rx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int DATA_NIBBLES = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sent_in,
    input  logic [7:0]                cfg_ctick_len,
    input  logic                      cfg_crc_mode,
    output logic                      rx_valid,
    output logic [3:0]                rx_status,
    output logic [4*DATA_NIBBLES-1:0] rx_data,
    output logic [3:0]                rx_crc,
    output logic                      rx_crc_err,
    output logic                      rx_frame_err
);
    localparam int         DW       = 4 * DATA_NIBBLES;
    localparam int         CLK_MHZ  = CLK_FREQ / 1000000;
    localparam logic [2:0] LAST_NIB = 3'(DATA_NIBBLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC
    } state_t;

    state_t        state, state_nxt;
    logic          sync_a, sync_b, sync_prev, fall;
    logic [7:0]    ctick_clamped;
    logic [13:0]   tick_clks_cfg, tick_clks, presc;
    logic [9:0]    tick_cnt;
    logic [10:0]   ticks;
    logic          round_up, is_sync, is_nib, timeout;
    logic [3:0]    nib;
    logic [2:0]    nib_cnt;
    logic [3:0]    status_sh;
    logic [DW-1:0] data_sh;
    logic          crc_match;
    logic          valid_nxt, crc_err_nxt, frame_err_nxt, frame_done;

    // Synchronize the line, keep the previous sample, register the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_a    <= sent_in;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            fall      <= sync_prev & ~sync_b;
        end
    end

    // Clamp the configured tick length to the legal 3..90 us window
    always_comb begin
        ctick_clamped = cfg_ctick_len;
        if (cfg_ctick_len < 8'd3) begin
            ctick_clamped = 8'd3;
        end else if (cfg_ctick_len > 8'd90) begin
            ctick_clamped = 8'd90;
        end
    end

    assign tick_clks_cfg = 14'(32'(ctick_clamped) * CLK_MHZ);

    // Tick length is sampled only while hunting; prescaler and tick counter
    // restart on every falling edge so each interval is measured from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_clks <= 14'(3 * CLK_MHZ);
            presc     <= '0;
            tick_cnt  <= '0;
        end else begin
            if (state == ST_HUNT) begin
                tick_clks <= tick_clks_cfg;
            end
            if (fall) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else if (presc >= tick_clks - 14'd1) begin
                presc <= '0;
                if (tick_cnt != 10'h3FF) begin
                    tick_cnt <= tick_cnt + 10'd1;
                end
            end else begin
                presc <= presc + 14'd1;
            end
        end
    end

    // Round the partial tick to nearest so +/- half a tick is tolerated
    assign round_up = (presc >= (tick_clks >> 1));
    assign ticks    = {1'b0, tick_cnt} + {10'd0, round_up};
    assign is_sync  = (ticks >= 11'd55) && (ticks <= 11'd57);
    assign is_nib   = (ticks >= 11'd12) && (ticks <= 11'd27);
    assign nib      = ticks[3:0] - 4'd12;
    assign timeout  = (tick_cnt == 10'h3FF);

`ifdef SENT_RX_CRC_CHECK_EN
    logic [3:0] crc_run, crc_final;

    function automatic logic [3:0] crc_step(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd13;
            4'd2:    r = 4'd7;
            4'd3:    r = 4'd10;
            4'd4:    r = 4'd14;
            4'd5:    r = 4'd3;
            4'd6:    r = 4'd9;
            4'd7:    r = 4'd4;
            4'd8:    r = 4'd1;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd6;
            4'd11:   r = 4'd11;
            4'd12:   r = 4'd15;
            4'd13:   r = 4'd2;
            4'd14:   r = 4'd8;
            default: r = 4'd5;
        endcase
        return r;
    endfunction

    // Running CRC over data nibbles only; reseeded when the status nibble lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_run <= 4'h5;
        end else if (fall && is_nib) begin
            if (state == ST_STATUS) begin
                crc_run <= 4'h5;
            end else if (state == ST_DATA) begin
                crc_run <= nib ^ crc_step(crc_run);
            end
        end
    end

    assign crc_final = cfg_crc_mode ? crc_step(crc_run) : crc_run;
    assign crc_match = (nib == crc_final);
`else
    logic crc_mode_unused;
    assign crc_mode_unused = cfg_crc_mode;
    assign crc_match       = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobe decisions; a fall wins over a simultaneous timeout
    always_comb begin
        state_nxt     = state;
        valid_nxt     = 1'b0;
        crc_err_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
        frame_done    = 1'b0;
        if (fall) begin
            case (state)
                ST_HUNT: state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (is_sync) begin
                        state_nxt = ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (is_nib) begin
                        state_nxt = ST_DATA;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_SYNC;
                    end
                end
                ST_DATA: begin
                    if (is_nib) begin
                        if (nib_cnt == LAST_NIB) begin
                            state_nxt = ST_CRC;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_SYNC;
                    end
                end
                ST_CRC: begin
                    state_nxt = ST_SYNC;
                    if (is_nib) begin
                        frame_done = 1'b1;
                        if (crc_match) begin
                            valid_nxt = 1'b1;
                        end else begin
                            crc_err_nxt = 1'b1;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end else if (timeout && (state != ST_HUNT)) begin
            state_nxt     = ST_HUNT;
            frame_err_nxt = (state == ST_STATUS) || (state == ST_DATA) ||
                            (state == ST_CRC);
        end
    end

    // Collect status and data nibbles as they arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_sh <= '0;
            data_sh   <= '0;
            nib_cnt   <= '0;
        end else if (fall && is_nib) begin
            if (state == ST_STATUS) begin
                status_sh <= nib;
                nib_cnt   <= '0;
            end else if (state == ST_DATA) begin
                data_sh <= DW'({data_sh, nib});
                nib_cnt <= nib_cnt + 3'd1;
            end
        end
    end

    // Output strobes and frame fields; fields hold until the next frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid     <= 1'b0;
            rx_crc_err   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_status    <= '0;
            rx_data      <= '0;
            rx_crc       <= '0;
        end else begin
            rx_valid     <= valid_nxt;
            rx_crc_err   <= crc_err_nxt;
            rx_frame_err <= frame_err_nxt;
            if (frame_done) begin
                rx_status <= status_sh;
                rx_data   <= data_sh;
                rx_crc    <= nib;
            end
        end
    end

endmodule

// File: tb/tb_sent_rx.sv
// tb_sent_rx: directed and randomized SENT frames against sent_rx.
// The DUT runs at 2 MHz so one 3 us tick is 6 clocks and frames stay short.
// Expectations follow SENT_RX_CRC_CHECK_EN the same way the design does.
module tb_sent_rx;
    localparam int LOW_TICKS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sent_in;
    logic [7:0]  cfg_ctick_len;
    logic        cfg_crc_mode;
    logic        rx_valid;
    logic [3:0]  rx_status;
    logic [23:0] rx_data;
    logic [3:0]  rx_crc;
    logic        rx_crc_err;
    logic        rx_frame_err;

    typedef struct {
        logic [3:0]  st;
        logic [23:0] d;
        logic [3:0]  c;
        logic        v;
        logic        ce;
        int          cyc;
    } ev_t;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   n_ferr    = 0;
    int   ferr_cyc  = 0;
    int   n_overlap = 0;
    int   tclk      = 6;
    bit   mark_next = 1'b0;
    int   term_q[$];
    ev_t  ev_q[$];
    ev_t  mon_e;

    sent_rx #(
        .CLK_FREQ    (2000000),
        .DATA_NIBBLES(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sent_in      (sent_in),
        .cfg_ctick_len(cfg_ctick_len),
        .cfg_crc_mode (cfg_crc_mode),
        .rx_valid     (rx_valid),
        .rx_status    (rx_status),
        .rx_data      (rx_data),
        .rx_crc       (rx_crc),
        .rx_crc_err   (rx_crc_err),
        .rx_frame_err (rx_frame_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every frame-completion strobe and every frame error
    always @(negedge clk) begin
        if (rx_valid || rx_crc_err) begin
            mon_e.st  = rx_status;
            mon_e.d   = rx_data;
            mon_e.c   = rx_crc;
            mon_e.v   = rx_valid;
            mon_e.ce  = rx_crc_err;
            mon_e.cyc = cyc;
            ev_q.push_back(mon_e);
        end
        if (rx_frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if (rx_valid && rx_frame_err) n_overlap = n_overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // CRC as polynomial arithmetic: crc = nib + crc*x^4 mod (x^4+x^3+x^2+1)
    function automatic logic [3:0] mulx4(input logic [3:0] c);
        logic [4:0] r;
        r = {1'b0, c};
        for (int i = 0; i < 4; i++) begin
            r = {r[3:0], 1'b0};
            if (r[4]) r = r ^ 5'h1D;
        end
        return r[3:0];
    endfunction

    function automatic logic [3:0] model_crc(input logic [23:0] d, input bit rec);
        logic [3:0] r;
        r = 4'h5;
        for (int i = 0; i < 6; i++) r = d[23-4*i -: 4] ^ mulx4(r);
        if (rec) r = mulx4(r);
        return r;
    endfunction

    // One SENT pulse: falling edge, low for 4 ticks, then high; n clocks fall-to-fall
    task automatic pulse(input int n);
        if (mark_next) begin
            term_q.push_back(cyc);
            mark_next = 1'b0;
        end
        sent_in = 1'b0;
        repeat (LOW_TICKS * tclk) @(posedge clk);
        #1;
        sent_in = 1'b1;
        repeat (n - LOW_TICKS * tclk) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] c,
                              input int extra, input int sync_t);
        pulse(sync_t * tclk + extra);
        pulse((12 + int'(st)) * tclk + extra);
        for (int i = 0; i < 6; i++) pulse((12 + int'(d[23-4*i -: 4])) * tclk + extra);
        pulse((12 + int'(c)) * tclk + extra);
        mark_next = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] st, input logic [23:0] d,
                               input logic [3:0] c, input bit ok);
        ev_t e;
        int  t;
        bit  exp_v, exp_ce;
`ifdef SENT_RX_CRC_CHECK_EN
        exp_v  = ok;
        exp_ce = !ok;
`else
        exp_v  = 1'b1;
        exp_ce = 1'b0;
`endif
        chk($sformatf("%s.strobe_seen", tag), 32'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            t = (term_q.size() > 0) ? term_q.pop_front() : -1000;
            chk($sformatf("%s.rx_valid", tag), e.v, exp_v);
            chk($sformatf("%s.rx_crc_err", tag), e.ce, exp_ce);
            chk($sformatf("%s.rx_status", tag), e.st, st);
            chk($sformatf("%s.rx_data", tag), e.d, d);
            chk($sformatf("%s.rx_crc", tag), e.c, c);
            chk($sformatf("%s.latency", tag), e.cyc - t, 4);
        end
    endtask

    task automatic check_quiet(input string tag, input int base_f, input int exp_ferr);
        chk($sformatf("%s.extra_strobes", tag), ev_q.size(), 0);
        chk($sformatf("%s.frame_err_count", tag), n_ferr - base_f, exp_ferr);
        ev_q.delete();
        term_q.delete();
    endtask

    initial begin
        logic [23:0] d;
        logic [3:0]  st;
        logic [3:0]  c;
        logic [3:0]  c2;
        logic [23:0] d2;
        int          base_f;
        int          ex;
        int          t;

        rst_n         = 1'b0;
        sent_in       = 1'b1;
        cfg_ctick_len = 8'd3;
        cfg_crc_mode  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset.ctrl", {rx_valid, rx_crc_err, rx_frame_err, rx_status, rx_crc}, 0);
        chk("reset.data", rx_data, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Legacy mode, all-zero data
        base_f = n_ferr;
        cfg_crc_mode = 1'b0;
        send_frame(4'h3, 24'h000000, 4'hF, 0, 56);
        pulse(12 * tclk);
        check_frame("legacy_zero", 4'h3, 24'h000000, 4'hF, model_crc(24'h000000, 1'b0) == 4'hF);
        check_quiet("legacy_zero", base_f, 0);

        // Recommended mode, good then bad CRC
        base_f = n_ferr;
        cfg_crc_mode = 1'b1;
        send_frame(4'h5, 24'h123456, 4'h2, 0, 56);
        pulse(12 * tclk);
        check_frame("rec_good", 4'h5, 24'h123456, 4'h2, model_crc(24'h123456, 1'b1) == 4'h2);
        send_frame(4'h5, 24'h123456, 4'hD, 0, 56);
        pulse(12 * tclk);
        check_frame("rec_bad", 4'h5, 24'h123456, 4'hD, model_crc(24'h123456, 1'b1) == 4'hD);
        check_quiet("rec", base_f, 0);

        // Back-to-back frames: 12-tick pause, then no pause
        base_f = n_ferr;
        d  = 24'($urandom);
        d2 = 24'($urandom);
        c  = model_crc(d, 1'b1);
        c2 = model_crc(d2, 1'b1);
        send_frame(4'h1, d, c, 0, 56);
        pulse(12 * tclk);
        send_frame(4'h2, d2, c2, 0, 56);
        pulse(12 * tclk);
        check_frame("pause_a", 4'h1, d, c, 1'b1);
        check_frame("pause_b", 4'h2, d2, c2, 1'b1);
        send_frame(4'h7, d2, c2, 0, 56);
        send_frame(4'h8, d, c, 0, 56);
        pulse(12 * tclk);
        check_frame("nopause_a", 4'h7, d2, c2, 1'b1);
        check_frame("nopause_b", 4'h8, d, c, 1'b1);
        check_quiet("b2b", base_f, 0);

        // Interval rounding: +3 and -2 clocks decode, +4 clocks shifts every nibble
        base_f = n_ferr;
        cfg_crc_mode = 1'b0;
        d = 24'h9A0F37;
        c = model_crc(d, 1'b0);
        send_frame(4'hC, d, c, 3, 56);
        pulse(12 * tclk);
        check_frame("stretch_plus3", 4'hC, d, c, 1'b1);
        send_frame(4'hC, d, c, -2, 56);
        pulse(12 * tclk);
        check_frame("stretch_minus2", 4'hC, d, c, 1'b1);
        cfg_crc_mode = 1'b1;
        c = model_crc(24'h000000, 1'b1);
        send_frame(4'h3, 24'h000000, c, 4, 56);
        pulse(12 * tclk);
        check_frame("stretch_plus4", 4'h4, 24'h111111, c + 4'h1,
                    model_crc(24'h111111, 1'b1) == c + 4'h1);
        check_quiet("stretch", base_f, 0);

        // Sync window edges: 55 ticks accepted, 58 ticks ignored
        base_f = n_ferr;
        d = 24'h5AA5C3;
        c = model_crc(d, 1'b1);
        send_frame(4'h6, d, c, 0, 55);
        pulse(12 * tclk);
        check_frame("sync55", 4'h6, d, c, 1'b1);
        check_quiet("sync55", base_f, 0);
        base_f = n_ferr;
        send_frame(4'h6, d, c, 0, 58);
        pulse(12 * tclk);
        check_quiet("sync58", base_f, 0);

        // 30-tick data interval gives a frame error; the next frame still decodes
        base_f = n_ferr;
        pulse(56 * tclk);
        pulse(15 * tclk);
        pulse(14 * tclk);
        pulse(30 * tclk);
        mark_next = 1'b1;
        pulse(12 * tclk);
        t = (term_q.size() > 0) ? term_q.pop_front() : -1000;
        chk("long_nibble.frame_err_latency", ferr_cyc - t, 4);
        check_quiet("long_nibble", base_f, 1);
        base_f = n_ferr;
        d = 24'hFEDCBA;
        c = model_crc(d, 1'b1);
        send_frame(4'hA, d, c, 0, 56);
        pulse(12 * tclk);
        check_frame("after_long", 4'hA, d, c, 1'b1);
        check_quiet("after_long", base_f, 0);

        // Line idle for 1100 ticks mid-frame: timeout error, back to hunting
        base_f = n_ferr;
        pulse(56 * tclk);
        pulse(15 * tclk);
        pulse(14 * tclk);
        pulse(1100 * tclk);
        check_quiet("timeout", base_f, 1);
        base_f = n_ferr;
        d = 24'h0F1E2D;
        c = model_crc(d, 1'b1);
        send_frame(4'hB, d, c, 0, 56);
        pulse(12 * tclk);
        check_frame("after_timeout", 4'hB, d, c, 1'b1);
        check_quiet("after_timeout", base_f, 0);

        // Random frames, random mode, some corrupted CRCs, random timing skew;
        // a tick-length change outside HUNT must be ignored
        for (int k = 0; k < 3; k++) begin
            base_f       = n_ferr;
            st           = 4'($urandom_range(0, 15));
            d            = 24'($urandom);
            cfg_crc_mode = 1'($urandom_range(0, 1));
            c            = model_crc(d, cfg_crc_mode);
            if ($urandom_range(0, 2) == 0) c = c ^ 4'($urandom_range(1, 15));
            ex = int'($urandom_range(0, 5)) - 2;
            if (k == 1) cfg_ctick_len = 8'd9;
            send_frame(st, d, c, ex, 56);
            pulse(12 * tclk);
            cfg_ctick_len = 8'd3;
            check_frame($sformatf("random%0d", k), st, d, c, c == model_crc(d, cfg_crc_mode));
            check_quiet($sformatf("random%0d", k), base_f, 0);
        end

        // Reset in the middle of the data nibbles
        pulse(56 * tclk);
        pulse(20 * tclk);
        pulse(17 * tclk);
        pulse(19 * tclk);
        sent_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset.ctrl", {rx_valid, rx_crc_err, rx_frame_err, rx_status, rx_crc}, 0);
        chk("mid_reset.data", rx_data, 0);
        sent_in       = 1'b1;
        cfg_ctick_len = 8'd5;
        tclk          = 10;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        base_f       = n_ferr;
        cfg_crc_mode = 1'b1;
        d = 24'h314159;
        c = model_crc(d, 1'b1);
        send_frame(4'h2, d, c, 0, 56);
        pulse(12 * tclk);
        check_frame("after_reset_5us", 4'h2, d, c, 1'b1);
        check_quiet("after_reset_5us", base_f, 0);

        // Tick length below 3 us is treated as 3 us
        rst_n = 1'b0;
        cfg_ctick_len = 8'd1;
        tclk          = 6;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        base_f = n_ferr;
        d = 24'h271828;
        c = model_crc(d, 1'b1);
        send_frame(4'h9, d, c, 0, 56);
        pulse(12 * tclk);
        check_frame("clamp_low", 4'h9, d, c, 1'b1);
        check_quiet("clamp_low", base_f, 0);

        chk("valid_with_frame_err", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
